// File: rtl/fp32_mult_arbiter.sv
// Round-robin arbiter sharing one non-pipelined fp32 multiplier among NUM_REQ requesters.
// One operation is outstanding at a time; the product returns only to the requester that issued it.
module fp32_mult_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TAG_W   = 2,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ*32-1:0]  req_input_a,
   input  logic [NUM_REQ*32-1:0]  req_input_b,
   input  logic [NUM_REQ-1:0]     req_input_STB,
   output logic [NUM_REQ-1:0]     req_BUSY,
   output logic [31:0]            req_output,
   output logic [NUM_REQ-1:0]     req_output_STB,
   input  logic [NUM_REQ-1:0]     req_output_module_BUSY,
   output logic [31:0]            mult_input_a,
   output logic [31:0]            mult_input_b,
   output logic                   mult_input_STB,
   input  logic                   mult_BUSY,
   input  logic [31:0]            mult_output,
   input  logic                   mult_output_STB,
   output logic                   mult_output_module_BUSY,
   output logic [TAG_W-1:0]       active_tag,
   output logic                   arb_busy,
   output logic [CNT_W-1:0]       op_count
);

   typedef enum logic [1:0] {
      ARB      = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RES = 2'd2,
      DELIVER  = 2'd3
   } state_t;

   state_t            r_state, w_nextState;
   logic [TAG_W-1:0]  r_rrPtr, w_nextRrPtr;
   logic [TAG_W-1:0]  r_tag, w_nextTag;
   logic [CNT_W-1:0]  r_opCount, w_nextOpCount;
   logic [31:0]       r_result, w_nextResult;
   logic [31:0]       r_opA, w_nextOpA;
   logic [31:0]       r_opB, w_nextOpB;
   logic              r_multStb, w_nextMultStb;

   logic [TAG_W-1:0]  w_grant;
   logic              w_grantFound;
   logic              w_grantOk;
   logic [TAG_W:0]    w_idx;
   logic [NUM_REQ-1:0] w_grantOneHot;
   logic [NUM_REQ-1:0] w_tagOneHot;

   // Scan downward so the last hit is the requester closest to r_rrPtr in wrap order.
   always_comb begin
      w_grant      = '0;
      w_grantFound = 1'b0;
      w_idx        = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_rrPtr} + (TAG_W+1)'(k);
         if (w_idx >= (TAG_W+1)'(NUM_REQ)) begin
            w_idx = w_idx - (TAG_W+1)'(NUM_REQ);
         end
         if (req_input_STB[w_idx[TAG_W-1:0]]) begin
            w_grant      = w_idx[TAG_W-1:0];
            w_grantFound = 1'b1;
         end
      end
   end

   // A product arriving in ARB is stale; it is drained and blocks granting for that cycle.
   assign w_grantOk     = (r_state == ARB) && w_grantFound && !mult_output_STB;
   assign w_grantOneHot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant;
   assign w_tagOneHot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_tag;

   assign req_BUSY                = w_grantOk ? ~w_grantOneHot : '1;
   assign req_output              = r_result;
   assign req_output_STB          = (r_state == DELIVER) ? w_tagOneHot : '0;
   assign mult_input_a            = r_opA;
   assign mult_input_b            = r_opB;
   assign mult_input_STB          = r_multStb;
   assign mult_output_module_BUSY = (r_state == ISSUE) || (r_state == DELIVER);
   assign active_tag              = r_tag;
   assign arb_busy                = (r_state != ARB);
   assign op_count                = r_opCount;

   always_comb begin
      w_nextState   = r_state;
      w_nextRrPtr   = r_rrPtr;
      w_nextTag     = r_tag;
      w_nextOpCount = r_opCount;
      w_nextResult  = r_result;
      w_nextOpA     = r_opA;
      w_nextOpB     = r_opB;
      w_nextMultStb = r_multStb;
      case (r_state)
         ARB: begin
            if (w_grantOk) begin
               w_nextOpA     = req_input_a[32*w_grant +: 32];
               w_nextOpB     = req_input_b[32*w_grant +: 32];
               w_nextTag     = w_grant;
               w_nextRrPtr   = (w_grant == TAG_W'(NUM_REQ-1)) ? '0 : w_grant + TAG_W'(1);
               w_nextMultStb = 1'b1;
               w_nextState   = ISSUE;
            end
         end
         ISSUE: begin
            if (r_multStb && !mult_BUSY) begin
               w_nextMultStb = 1'b0;
               w_nextState   = WAIT_RES;
            end
         end
         WAIT_RES: begin
            if (mult_output_STB) begin
               w_nextResult = mult_output;
               w_nextState  = DELIVER;
            end
         end
         DELIVER: begin
            if (!req_output_module_BUSY[r_tag]) begin
               w_nextOpCount = r_opCount + CNT_W'(1);
               w_nextState   = ARB;
            end
         end
         default: w_nextState = ARB;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ARB;
         r_rrPtr   <= '0;
         r_tag     <= '0;
         r_opCount <= '0;
         r_result  <= '0;
         r_opA     <= '0;
         r_opB     <= '0;
         r_multStb <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_rrPtr   <= w_nextRrPtr;
         r_tag     <= w_nextTag;
         r_opCount <= w_nextOpCount;
         r_result  <= w_nextResult;
         r_opA     <= w_nextOpA;
         r_opB     <= w_nextOpB;
         r_multStb <= w_nextMultStb;
      end
   end

endmodule

// File: tb/tb_fp32_mult_arbiter.sv
// Scoreboard bench for fp32_mult_arbiter: requester driver, multiplier stub and output monitor run
// as separate processes; expected grants and products come from a round-robin model and fpMul().
module tb_fp32_mult_arbiter;
   localparam int N  = 4;
   localparam int TW = 2;
   localparam int CW = 16;

   logic            clk, rst;
   logic [N*32-1:0] reqA, reqB;
   logic [N-1:0]    reqStb, reqBusy, reqOutStb, reqOutBusy;
   logic [31:0]     reqOut, multA, multB, multOut;
   logic            multStb, multBusy, multOutStb, multOutBusy;
   logic [TW-1:0]   activeTag;
   logic            arbBusy;
   logic [CW-1:0]   opCount;

   typedef struct packed {logic [TW-1:0] tag; logic [31:0] data;} exp_t;
   typedef struct packed {logic [31:0] a; logic [31:0] b;} op_t;

   exp_t        expQ[$];
   op_t         opQ[N][$];
   int          grantLog[$];
   int          errors = 0;
   int          checks = 0;
   logic [N-1:0] pend;
   logic [31:0] pA[N], pB[N];
   bit          outstanding, inReset;
   logic [TW-1:0] curTag;
   int          rrStart, delivered, grants, multTransfers;
   int          stubState, stubCnt, multLatency, holdCnt;
   logic [31:0] capA, capB, firstA, firstB, lastData;
   logic [N-1:0] lastStb, outBusyForce, expBusy, gVec;
   bit          haveFirst, outBusyRandom, multBusyRandom;
   int          eg, gIdx;

   fp32_mult_arbiter #(.NUM_REQ(N), .TAG_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .req_input_a(reqA), .req_input_b(reqB), .req_input_STB(reqStb), .req_BUSY(reqBusy),
      .req_output(reqOut), .req_output_STB(reqOutStb), .req_output_module_BUSY(reqOutBusy),
      .mult_input_a(multA), .mult_input_b(multB), .mult_input_STB(multStb), .mult_BUSY(multBusy),
      .mult_output(multOut), .mult_output_STB(multOutStb), .mult_output_module_BUSY(multOutBusy),
      .active_tag(activeTag), .arb_busy(arbBusy), .op_count(opCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: bound expired", name);
   endtask

   // Reference fp32 product for normal operands, round to nearest even.
   function automatic logic [31:0] fpMul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [24:0] m;
      logic        g, st;
      int          e;
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         m = {1'b0, p[47:24]}; g = p[23]; st = |p[22:0]; e = e + 1;
      end else begin
         m = {1'b0, p[46:23]}; g = p[22]; st = |p[21:0];
      end
      if (g && (st || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1; e = e + 1;
      end
      return {a[31] ^ b[31], e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] randOp();
      return {1'($urandom_range(1)), 8'($urandom_range(150, 100)), 23'($urandom)};
   endfunction

   function automatic int expGrant(input logic [N-1:0] p, input int start);
      for (int d = 0; d < N; d++) begin
         if (p[(start + d) % N]) return (start + d) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] oneHot(input logic [TW-1:0] t);
      logic [N-1:0] v;
      v = '0;
      v[t] = 1'b1;
      return v;
   endfunction

   task automatic applyStimulus(input int i, input logic [31:0] a, input logic [31:0] b);
      op_t o;
      o.a = a;
      o.b = b;
      opQ[i].push_back(o);
   endtask

   function automatic bit allIdle();
      bit q;
      q = (expQ.size() == 0) && !outstanding && (pend == '0) && (stubState == 0);
      for (int i = 0; i < N; i++) if (opQ[i].size() != 0) q = 0;
      return q;
   endfunction

   task automatic waitIdle(input int bound, input string name);
      int n;
      n = 0;
      while (!allIdle()) begin
         @(negedge clk);
         n++;
         if (n > bound) begin
            failNow(name);
            return;
         end
      end
   endtask

   task automatic doReset();
      rst = 1'b0;
      inReset = 1;
      expQ.delete();
      outstanding = 0;
      rrStart = 0;
      delivered = 0;
      haveFirst = 0;
      @(negedge clk);
      rst = 1'b1;
      inReset = 0;
   endtask

   // Requester side: present queued operands, check BUSY against round-robin model, log grants.
   initial begin
      reqStb = '0; reqA = '0; reqB = '0; pend = '0;
      forever begin
         @(negedge clk);
         #1;
         if (inReset) begin
            pend = '0;
            reqStb = '0;
         end else begin
            for (int i = 0; i < N; i++) begin
               if (!pend[i] && opQ[i].size() > 0) begin
                  pA[i] = opQ[i][0].a;
                  pB[i] = opQ[i][0].b;
                  void'(opQ[i].pop_front());
                  pend[i] = 1'b1;
               end
               reqStb[i] = pend[i];
               reqA[32*i +: 32] = pA[i];
               reqB[32*i +: 32] = pB[i];
            end
         end
         #1;
         if (!inReset) begin
            expBusy = '1;
            if (!outstanding && !multOutStb) begin
               eg = expGrant(pend, rrStart);
               if (eg >= 0) expBusy[eg] = 1'b0;
            end
            checkOutput("req_BUSY", reqBusy, expBusy);
            checkOutput("arb_busy", arbBusy, outstanding);
            if (outstanding) checkOutput("active_tag", activeTag, curTag);
            gVec = reqStb & ~reqBusy;
            if (gVec != '0) begin
               for (int i = 0; i < N; i++) if (gVec[i]) gIdx = i;
               pend[gIdx] = 1'b0;
               expQ.push_back('{tag: TW'(gIdx), data: fpMul(pA[gIdx], pB[gIdx])});
               rrStart = (gIdx + 1) % N;
               grantLog.push_back(gIdx);
               outstanding = 1;
               curTag = TW'(gIdx);
               grants++;
            end
         end
      end
   end

   // Multiplier stub with configurable latency and BUSY back-pressure.
   initial begin
      multBusy = 1'b0; multOutStb = 1'b0; multOut = '0; stubState = 0; stubCnt = 0;
      forever begin
         @(negedge clk);
         #1;
         if (stubState == 1) begin
            stubCnt--;
            if (stubCnt == 0) stubState = 2;
         end
         multOutStb = (stubState == 2);
         multOut = (stubState == 2) ? fpMul(capA, capB) : 32'h0;
         if (stubState != 0) multBusy = 1'b1;
         else if (holdCnt > 0 && multStb) begin
            multBusy = 1'b1;
            holdCnt--;
         end else multBusy = multBusyRandom ? ($urandom_range(3) == 0) : 1'b0;
         #1;
         if (stubState == 0 && multStb) begin
            if (haveFirst) begin
               checkOutput("mult_input_a held", multA, firstA);
               checkOutput("mult_input_b held", multB, firstB);
            end
            if (!multBusy) begin
               capA = multA; capB = multB;
               stubState = 1;
               stubCnt = (multLatency > 0) ? multLatency : int'($urandom_range(4, 1));
               multTransfers++;
               haveFirst = 0;
            end else begin
               firstA = multA; firstB = multB; haveFirst = 1;
            end
         end else if (stubState == 2 && !multOutBusy) begin
            stubState = 0;
         end
      end
   end

   // Output monitor: compare each presented result against the scoreboard head.
   initial begin
      reqOutBusy = '0;
      forever begin
         @(negedge clk);
         #1;
         for (int i = 0; i < N; i++)
            reqOutBusy[i] = outBusyForce[i] ? 1'b1 : (outBusyRandom ? ($urandom_range(2) == 0) : 1'b0);
         #2;
         if (!inReset && reqOutStb != '0) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected req_output_STB: got %b, required 0000", reqOutStb);
            end else begin
               checkOutput("req_output_STB", reqOutStb, oneHot(expQ[0].tag));
               checkOutput("req_output", reqOut, expQ[0].data);
               checkOutput("op_count", opCount, delivered[15:0]);
               if ((reqOutStb & ~reqOutBusy) != '0) begin
                  lastData = reqOut;
                  lastStb = reqOutStb;
                  void'(expQ.pop_front());
                  delivered++;
                  outstanding = 0;
               end
            end
         end
      end
   end

   initial begin
      int n, t0;
      rst = 1'b0; inReset = 1; outBusyForce = '0; outBusyRandom = 0; multBusyRandom = 0;
      multLatency = 2; holdCnt = 0; outstanding = 0; rrStart = 0; delivered = 0;
      grants = 0; multTransfers = 0; haveFirst = 0; curTag = '0; lastData = '0; lastStb = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      inReset = 0;
      checkOutput("reset arb_busy", arbBusy, 0);
      checkOutput("reset op_count", opCount, 0);
      checkOutput("reset req_output_STB", reqOutStb, 0);
      checkOutput("reset req_output", reqOut, 0);
      checkOutput("reset mult_input_STB", multStb, 0);
      checkOutput("reset mult_input_a", multA, 0);
      checkOutput("reset active_tag", activeTag, 0);
      checkOutput("reset req_BUSY", reqBusy, 4'hF);
      checkOutput("reset mult_output_module_BUSY", multOutBusy, 0);

      $display("[TB] T1 single request");
      applyStimulus(0, 32'h40000000, 32'h40400000);
      waitIdle(200, "T1 drain");
      checkOutput("T1 result", lastData, 32'h40C00000);
      checkOutput("T1 STB", lastStb, 4'b0001);
      checkOutput("T1 op_count", opCount, 1);

      $display("[TB] T2 all requesters");
      doReset();
      grantLog.delete();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) applyStimulus(i, randOp(), randOp());
      waitIdle(500, "T2 drain");
      checkOutput("T2 grant count", grantLog.size(), 8);
      for (int k = 0; k < 8; k++)
         if (k < grantLog.size()) checkOutput($sformatf("T2 grant %0d", k), grantLog[k], k % N);

      $display("[TB] T3 output back-pressure");
      outBusyForce = 4'b0100;
      applyStimulus(2, 32'h3FC00000, 32'h3FC00000);
      applyStimulus(0, randOp(), randOp());
      n = 0;
      while (!reqOutStb[2] && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) failNow("T3 wait STB[2]");
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checkOutput("T3 STB held", reqOutStb, 4'b0100);
         checkOutput("T3 result held", reqOut, 32'h40100000);
         checkOutput("T3 no grant", arbBusy, 1);
      end
      outBusyForce = '0;
      waitIdle(300, "T3 drain");

      $display("[TB] T4 multiplier back-pressure");
      holdCnt = 5;
      t0 = multTransfers;
      applyStimulus(1, randOp(), randOp());
      waitIdle(300, "T4 drain");
      checkOutput("T4 transfers", multTransfers - t0, 1);
      checkOutput("T4 hold consumed", holdCnt, 0);

      $display("[TB] T5 reset while waiting");
      multLatency = 12;
      applyStimulus(1, 32'h3F800000, 32'hBF800000);
      n = 0;
      while (stubState != 1 && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) failNow("T5 wait issue");
      doReset();
      n = 0;
      while (!(stubState == 1 && stubCnt == 1) && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) failNow("T5 wait product");
      applyStimulus(0, randOp(), randOp());
      @(negedge clk);
      checkOutput("T5 op_count", opCount, 0);
      checkOutput("T5 no STB", reqOutStb, 0);
      checkOutput("T5 result cleared", reqOut, 0);
      checkOutput("T5 no grant on stale", arbBusy, 0);
      multLatency = 2;
      waitIdle(300, "T5 drain");
      checkOutput("T5 op_count after", opCount, 1);

      $display("[TB] T6 request during delivery");
      outBusyForce = 4'b1000;
      applyStimulus(3, randOp(), randOp());
      n = 0;
      while (!reqOutStb[3] && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) failNow("T6 wait STB[3]");
      outBusyForce = '0;
      applyStimulus(1, randOp(), randOp());
      @(negedge clk);
      checkOutput("T6 req_BUSY", reqBusy, 4'b1101);
      checkOutput("T6 arb_busy", arbBusy, 0);
      waitIdle(300, "T6 drain");
      if (grantLog.size() > 0) checkOutput("T6 last grant", grantLog[grantLog.size()-1], 1);

      $display("[TB] random traffic");
      outBusyRandom = 1;
      multBusyRandom = 1;
      multLatency = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if ($urandom_range(2) == 0) applyStimulus(int'($urandom_range(N-1)), randOp(), randOp());
      end
      waitIdle(5000, "random drain");
      checkOutput("final op_count", opCount, delivered[15:0]);
      checkOutput("mult transfers vs grants", multTransfers, grants);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
